counter_fsm: RTL and testbench

- Burst-read sequencer for the FIFO subsystem.
- A one-cycle (or longer) en request starts a burst of exactly COUNTER_LEN consecutive read strobes.
- An index counter is exported alongside the strobes for addressing or monitoring.
- Moore FSM with registered outputs; sits between the FIFO control logic and the read port.

---
 rtl/counter_fsm_pkg.sv | 7 +
 rtl/counter_fsm_cnt.sv | 19 +
 rtl/counter_fsm.sv | 38 +++
 tb/tb_counter_fsm.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_fsm_pkg.sv
// counter_fsm_pkg: shared state type and width helper for the burst-read sequencer
package counter_fsm_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  function automatic int cnt_width(input int len);
    return 2 ** $clog2(len);
  endfunction
endpackage

// File: rtl/counter_fsm_cnt.sv
// counter_fsm_cnt: CW-bit up-counter with clear, increment and terminal flag at LEN-1
module counter_fsm_cnt import counter_fsm_pkg::*; #(
  parameter int CW  = 8,
  parameter int LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          term
);
  assign term = count == CW'(LEN - 1);
  // clear has priority; otherwise count up when asked
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/counter_fsm.sv
// counter_fsm: burst-read sequencer issuing COUNTER_LEN read strobes per en request (optional COUNTER_FSM_RESTART_EN lets en restart a running burst)
module counter_fsm import counter_fsm_pkg::*; #(
  parameter  int COUNTER_LEN = 8,
  localparam int CW          = cnt_width(COUNTER_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] counter_out,
  output logic          read
);
  state_t state, next;
  logic   term, restart, clr, inc;
  counter_fsm_cnt #(.CW(CW), .LEN(COUNTER_LEN)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .count(counter_out), .term(term)
  );
  // state register; IDLE is the all-zero encoding so a zeroed power-up is already idle
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next state and counter control; the counter clears whenever we are not mid-burst
  always_comb begin
`ifdef COUNTER_FSM_RESTART_EN
    restart = en;
`else
    restart = 1'b0;
`endif
    next = (state == IDLE)  ? (en ? COUNT : IDLE) :
           (state == COUNT) ? ((restart || !term) ? COUNT : DONE) :
           (state == DONE)  ? (restart ? COUNT : IDLE) : IDLE;
    clr  = (state != COUNT) || restart;
    inc  = (state == COUNT) && !term;
  end
  // read strobe registered from the upcoming state so it aligns with COUNT
  always_ff @(posedge clk or posedge rst)
    if (rst) read <= 1'b0;
    else read <= next == COUNT;
endmodule

// File: tb/tb_counter_fsm.sv
// tb_counter_fsm: randomized and directed checks of counter_fsm (LEN 8, 5, 2) against a burst-position model
module tb_counter_fsm;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] co8, co5;
  logic [1:0] co2;
  logic       rd8, rd5, rd2;
  logic [7:0] co [3];
  logic       rd [3];
  int         lens [3] = '{8, 5, 2};
  int         pos [3] = '{-1, -1, -1};
  int         checks = 0, errors = 0;

  counter_fsm #(.COUNTER_LEN(8)) dut8 (.clk(clk), .rst(rst), .en(en), .counter_out(co8), .read(rd8));
  counter_fsm #(.COUNTER_LEN(5)) dut5 (.clk(clk), .rst(rst), .en(en), .counter_out(co5), .read(rd5));
  counter_fsm #(.COUNTER_LEN(2)) dut2 (.clk(clk), .rst(rst), .en(en), .counter_out(co2), .read(rd2));

  assign co[0] = co8;
  assign co[1] = co5;
  assign co[2] = {6'b0, co2};
  assign rd[0] = rd8;
  assign rd[1] = rd5;
  assign rd[2] = rd2;

  always #5 clk = ~clk;

  // pos = -1 idle, 0..LEN-1 index of the read in progress, LEN the single done cycle
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 3; k++) begin
      if (rst) pos[k] = -1;
      else if (pos[k] == -1) pos[k] = en ? 0 : -1;
`ifdef COUNTER_FSM_RESTART_EN
      else if (en) pos[k] = 0;
`endif
      else if (pos[k] == lens[k]) pos[k] = -1;
      else pos[k] = pos[k] + 1;
    end

  function automatic logic exp_rd(input int k);
    return pos[k] >= 0 && pos[k] < lens[k];
  endfunction

  function automatic logic [7:0] exp_co(input int k);
    return 8'(pos[k] < 0 ? 0 : (pos[k] >= lens[k] ? lens[k] - 1 : pos[k]));
  endfunction

  task automatic cycle(input logic e);
    en = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== 1'b0 || co[k] !== 8'd0) begin
          errors++;
          $display("FAIL reset len=%0d: read=%b count=%0d, expected read=0 count=0", lens[k], rd[k], co[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int reads [3] = '{0, 0, 0};
    int maxc [3] = '{0, 0, 0};
    cycle(1'b1);
    repeat (12) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== exp_rd(k) || co[k] !== exp_co(k)) begin
          errors++;
          $display("FAIL basic len=%0d: read=%b count=%0d, expected read=%b count=%0d", lens[k], rd[k], co[k], exp_rd(k), exp_co(k));
        end
        if (rd[k] === 1'b1) reads[k]++;
        if (rd[k] === 1'b1 && int'(co[k]) > maxc[k]) maxc[k] = int'(co[k]);
      end
      cycle(1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (reads[k] != lens[k] || maxc[k] != lens[k] - 1) begin
        errors++;
        $display("FAIL burst_len len=%0d: reads=%0d max=%0d, expected reads=%0d max=%0d", lens[k], reads[k], maxc[k], lens[k], lens[k] - 1);
      end
    end
  endtask

  task automatic test_en_two;
    cycle(1'b1);
    cycle(1'b1);
    repeat (14) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== exp_rd(k) || co[k] !== exp_co(k)) begin
          errors++;
          $display("FAIL en_two len=%0d: read=%b count=%0d, expected read=%b count=%0d", lens[k], rd[k], co[k], exp_rd(k), exp_co(k));
        end
      end
      cycle(1'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic pat [20];
    for (int i = 0; i < 20; i++) pat[i] = (i == 0 || i == 9 || i == 10);
    for (int i = 0; i < 20; i++) begin
      cycle(pat[i]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== exp_rd(k) || co[k] !== exp_co(k)) begin
          errors++;
          $display("FAIL back_to_back len=%0d: read=%b count=%0d, expected read=%b count=%0d", lens[k], rd[k], co[k], exp_rd(k), exp_co(k));
        end
      end
    end
    repeat (12) cycle(1'b0);
  endtask

  task automatic test_reset_mid;
    cycle(1'b1);
    repeat (3) cycle(1'b0);
    checks++;
    if (co8 !== 8'd3 || rd8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: read=%b count=%0d, expected read=1 count=3", rd8, co8);
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd[k] !== 1'b0 || co[k] !== 8'd0) begin
        errors++;
        $display("FAIL async_reset len=%0d: read=%b count=%0d, expected read=0 count=0", lens[k], rd[k], co[k]);
      end
    end
    @(negedge clk);
    repeat (3) begin
      cycle(1'b1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== 1'b0 || co[k] !== 8'd0) begin
          errors++;
          $display("FAIL reset_hold len=%0d: read=%b count=%0d, expected read=0 count=0", lens[k], rd[k], co[k]);
        end
      end
    end
    en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_continuous;
    for (int i = 0; i < 42; i++) begin
      cycle(i < 30);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== exp_rd(k) || co[k] !== exp_co(k)) begin
          errors++;
          $display("FAIL continuous len=%0d: read=%b count=%0d, expected read=%b count=%0d", lens[k], rd[k], co[k], exp_rd(k), exp_co(k));
        end
      end
    end
  endtask

  task automatic test_random;
    repeat (300) begin
      cycle($urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd[k] !== exp_rd(k) || co[k] !== exp_co(k)) begin
          errors++;
          $display("FAIL random len=%0d: read=%b count=%0d, expected read=%b count=%0d", lens[k], rd[k], co[k], exp_rd(k), exp_co(k));
        end
      end
    end
    repeat (12) cycle(1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_en_two;
    test_back_to_back;
    test_reset_mid;
    test_continuous;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
